plot_cache: RTL and testbench

PLOT_CACHE -- requirements
Module: plot_cache

---
 rtl/plot_cache_pkg.sv | 14 +
 rtl/plot_cache_if.sv | 37 +++
 rtl/plot_cache_merge.sv | 20 ++
 rtl/plot_cache.sv | 150 +++++++++++++++
 tb/tb_plot_cache.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_cache_pkg.sv
// Shared types and default geometry for the single-row bitplane plot cache.
package plot_cache_pkg;

    localparam int BPP_DEF    = 4;
    localparam int PIXELS_DEF = 8;
    localparam int ROWW_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/plot_cache_if.sv
// Plot request, flush control and bitplane memory bus of the plot cache.
interface plot_cache_if
    import plot_cache_pkg::*;
#(
    parameter int BPP    = BPP_DEF,
    parameter int PIXELS = PIXELS_DEF,
    parameter int ROWW   = ROWW_DEF
);
    localparam int PXW = $clog2(PIXELS);
    localparam int PW  = $clog2(BPP);

    logic              plot_valid;
    logic              plot_ready;
    logic [ROWW-1:0]   plot_row;
    logic [PXW-1:0]    plot_x;
    logic [BPP-1:0]    plot_color;
    logic              flush;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ROWW-1:0]   mem_row;
    logic [PW-1:0]     mem_plane;
    logic [PIXELS-1:0] mem_wdata;
    logic [PIXELS-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  plot_valid, plot_row, plot_x, plot_color, flush, mem_rdata, mem_ack,
        output plot_ready, busy, mem_req, mem_we, mem_row, mem_plane, mem_wdata
    );

    modport master (
        output plot_valid, plot_row, plot_x, plot_color, flush, mem_rdata, mem_ack,
        input  plot_ready, busy, mem_req, mem_we, mem_row, mem_plane, mem_wdata
    );

endinterface

// File: rtl/plot_cache_merge.sv
// Builds one plane write word: cached pixels take their colour bit, the rest keep memory contents.
module plot_cache_merge
    import plot_cache_pkg::*;
#(
    parameter int BPP    = BPP_DEF,
    parameter int PIXELS = PIXELS_DEF
) (
    input  logic [PIXELS-1:0][BPP-1:0] i_color,
    input  logic [PIXELS-1:0]          i_valid,
    input  logic [$clog2(BPP)-1:0]     i_plane,
    input  logic [PIXELS-1:0]          i_rdata,
    output logic [PIXELS-1:0]          o_wdata
);

    // Pixel 0 lands in the MSB of the plane word.
    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_px
        assign o_wdata[PIXELS-1-gi] = i_valid[gi] ? i_color[gi][i_plane] : i_rdata[PIXELS-1-gi];
    end

endmodule

// File: rtl/plot_cache.sv
// One-row pixel cache that merges plotted pixels into bitplane memory by read-modify-write.
module plot_cache
    import plot_cache_pkg::*;
#(
    parameter int BPP    = BPP_DEF,
    parameter int PIXELS = PIXELS_DEF,
    parameter int ROWW   = ROWW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    plot_cache_if.slave  bus
);

    localparam int PXW = $clog2(PIXELS);
    localparam int PW  = $clog2(BPP);
    localparam logic [PW-1:0] LAST_PLANE = PW'(BPP - 1);

    state_t                    r_state;
    logic [PW-1:0]             r_plane;
    logic                      r_pending;
    logic [PIXELS-1:0][BPP-1:0] r_color;
    logic [PIXELS-1:0]         r_valid;
    logic [ROWW-1:0]           r_tag;
    logic [PIXELS-1:0]         r_rdata;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [ROWW-1:0]           r_mem_row;
    logic [PW-1:0]             r_mem_plane;
    logic [PIXELS-1:0]         r_mem_wdata;

    logic              w_mask_any;
    logic              w_mask_full;
    logic              w_row_hit;
    logic              w_plot_ready;
    logic              w_plot_fire;
    logic              w_start;
    logic [PIXELS-1:0] w_px_we;
    logic [PIXELS-1:0] w_wdata;

    assign w_mask_any  = |r_valid;
    assign w_mask_full = &r_valid;
    assign w_row_hit   = (bus.plot_row == r_tag);

    // A full mask is about to be written out, so no new plot may slip in that cycle.
    assign w_plot_ready = (r_state == ST_IDLE) && !r_pending && !w_mask_full
                          && (!w_mask_any || w_row_hit);
    assign w_plot_fire  = bus.plot_valid && w_plot_ready;

    assign w_start = (r_state == ST_IDLE) && (w_mask_full
                     || (w_mask_any && (r_pending || (bus.plot_valid && !w_row_hit))));

    for (genvar gi = 0; gi < PIXELS; gi++) begin : g_px_we
        assign w_px_we[gi] = w_plot_fire && (bus.plot_x == PXW'(gi));
    end

    plot_cache_merge #(
        .BPP    (BPP),
        .PIXELS (PIXELS)
    ) u_merge (
        .i_color (r_color),
        .i_valid (r_valid),
        .i_plane (r_plane),
        .i_rdata (r_rdata),
        .o_wdata (w_wdata)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIXELS; i++) begin
            if (w_px_we[i]) begin
                r_color[i] <= bus.plot_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_plane     <= '0;
            r_pending   <= 1'b0;
            r_valid     <= '0;
            r_tag       <= '0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_row   <= '0;
            r_mem_plane <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (bus.flush) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_plot_fire) begin
                        r_valid <= r_valid | w_px_we;
                        r_tag   <= bus.plot_row;
                    end
                    if (w_start) begin
                        r_state   <= w_mask_full ? ST_WR : ST_RD;
                        r_plane   <= '0;
                        r_pending <= 1'b0;
                    end else if (r_pending && !w_mask_any) begin
                        r_pending <= 1'b0;
                    end
                end
                // Each state spends one cycle with mem_req low before issuing, giving the post-ack gap.
                ST_RD: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_row   <= r_tag;
                        r_mem_plane <= r_plane;
                    end else if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= bus.mem_rdata;
                        r_state   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (!r_mem_req) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_row   <= r_tag;
                        r_mem_plane <= r_plane;
                        r_mem_wdata <= w_wdata;
                    end else if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_plane == LAST_PLANE) begin
                            r_state <= ST_IDLE;
                            r_valid <= '0;
                        end else begin
                            r_plane <= r_plane + PW'(1);
                            r_state <= w_mask_full ? ST_WR : ST_RD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.plot_ready = w_plot_ready;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_row    = r_mem_row;
    assign bus.mem_plane  = r_mem_plane;
    assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_plot_cache.sv
// Directed bench for plot_cache: a scripted plot/flush sequence against a logging memory responder.
module tb_plot_cache;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    plot_cache_if #(.BPP(4), .PIXELS(8), .ROWW(16)) bus ();

    plot_cache #(.BPP(4), .PIXELS(8), .ROWW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          ack_delay  = 0;
    logic [7:0]  rd_value   = 8'h00;
    int          n_tx       = 0;
    int          req_cycles = 0;
    logic        tx_we    [0:31];
    logic [15:0] tx_row   [0:31];
    logic [1:0]  tx_plane [0:31];
    logic [7:0]  tx_wdata [0:31];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks each request after ack_delay extra cycles and logs it.
    initial begin
        int          wait_cnt;
        logic [26:0] snap;
        logic [26:0] first_snap;
        wait_cnt      = 0;
        first_snap    = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            snap = {bus.mem_we, bus.mem_row, bus.mem_plane, bus.mem_wdata};
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
                check_eq("gap_after_ack", bus.mem_req, 1'b0);
            end else if (bus.mem_req) begin
                req_cycles++;
                if (wait_cnt == 0) first_snap = snap;
                else check_eq("req_stable", snap, first_snap);
                if (wait_cnt >= ack_delay) begin
                    if (n_tx < 32) begin
                        tx_we[n_tx]    = bus.mem_we;
                        tx_row[n_tx]   = bus.mem_row;
                        tx_plane[n_tx] = bus.mem_plane;
                        tx_wdata[n_tx] = bus.mem_wdata;
                    end
                    $display("tx %0d: %s row=%0d plane=%0d wdata=0x%02h rdata=0x%02h",
                             n_tx, bus.mem_we ? "WR" : "RD", bus.mem_row, bus.mem_plane,
                             bus.mem_wdata, rd_value);
                    n_tx++;
                    bus.mem_rdata = rd_value;
                    bus.mem_ack   = 1'b1;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_plot(input logic [15:0] row, input logic [2:0] x, input logic [3:0] c);
        bit ok;
        ok             = 1'b0;
        bus.plot_valid = 1'b1;
        bus.plot_row   = row;
        bus.plot_x     = x;
        bus.plot_color = c;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (bus.plot_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.plot_valid = 1'b0;
        check_eq("plot_accept", ok, 1'b1);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_seq(input string name);
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        check_eq({name, "_seq_done"}, done, 1'b1);
    endtask

    task automatic check_flush(input string name, input bit with_rd, input logic [15:0] row,
                               input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] exp_w [4];
        int idx;
        exp_w[0] = w0;
        exp_w[1] = w1;
        exp_w[2] = w2;
        exp_w[3] = w3;
        check_eq({name, "_ntx"}, n_tx, with_rd ? 8 : 4);
        for (int p = 0; p < 4; p++) begin
            idx = with_rd ? 2 * p + 1 : p;
            if (with_rd)
                check_eq({name, "_rd"}, {tx_we[idx-1], tx_plane[idx-1], tx_row[idx-1]},
                         {1'b0, 2'(p), row});
            check_eq({name, "_wr"}, {tx_we[idx], tx_plane[idx], tx_row[idx]}, {1'b1, 2'(p), row});
            check_eq({name, "_wdata"}, tx_wdata[idx], exp_w[p]);
        end
    endtask

    initial begin
        int bad;
        int saved;
        bit seen;
        bit done;

        reset          = 1'b1;
        bus.plot_valid = 1'b0;
        bus.plot_row   = '0;
        bus.plot_x     = '0;
        bus.plot_color = '0;
        bus.flush      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", bus.plot_ready, 1'b1);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_req", bus.mem_req, 1'b0);
        check_eq("rst_we", bus.mem_we, 1'b0);
        @(negedge clk);

        // Full row: write-only sequence triggered by the completed mask.
        n_tx = 0;
        for (int x = 0; x < 8; x++) do_plot(16'd5, 3'(x), 4'(x));
        wait_seq("full");
        check_flush("full", 1'b0, 16'd5, 8'h55, 8'h33, 8'h0F, 8'h00);
        bus.plot_row = 16'd9;
        #1;
        check_eq("full_mask_clear", bus.plot_ready, 1'b1);

        // Partial row with explicit flush.
        n_tx     = 0;
        rd_value = 8'h00;
        do_plot(16'd3, 3'd2, 4'hF);
        pulse_flush();
        wait_seq("part");
        check_flush("part", 1'b1, 16'd3, 8'h20, 8'h20, 8'h20, 8'h20);

        // Row change with a held plot to a new row.
        n_tx     = 0;
        rd_value = 8'hFF;
        do_plot(16'd3, 3'd0, 4'h1);
        bus.plot_valid = 1'b1;
        bus.plot_row   = 16'd4;
        bus.plot_x     = 3'd3;
        bus.plot_color = 4'hA;
        bad  = 0;
        seen = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                seen = 1'b1;
                if (bus.plot_ready) bad++;
            end else if (seen) begin
                check_eq("rc_ready_first_idle", bus.plot_ready, 1'b1);
                done = 1'b1;
            end
        end
        @(negedge clk);
        bus.plot_valid = 1'b0;
        check_eq("rc_seq_done", done, 1'b1);
        check_eq("rc_ready_while_busy", bad, 0);
        check_flush("rc", 1'b1, 16'd3, 8'hFF, 8'h7F, 8'h7F, 8'h7F);
        n_tx     = 0;
        rd_value = 8'h00;
        pulse_flush();
        wait_seq("rc2");
        check_flush("rc2", 1'b1, 16'd4, 8'h00, 8'h10, 8'h00, 8'h10);

        // Slow memory: every ack delayed by three cycles.
        ack_delay = 3;
        n_tx      = 0;
        rd_value  = 8'h81;
        do_plot(16'd7, 3'd1, 4'h5);
        pulse_flush();
        wait_seq("slow");
        check_flush("slow", 1'b1, 16'd7, 8'hC1, 8'h81, 8'hC1, 8'h81);

        // Reset during the plane-1 read.
        n_tx     = 0;
        rd_value = 8'h00;
        do_plot(16'd2, 3'd0, 4'h3);
        pulse_flush();
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_req && !bus.mem_we && bus.mem_plane == 2'd1) done = 1'b1;
        end
        check_eq("rst_found_plane1_rd", done, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_abort_req", bus.mem_req, 1'b0);
        check_eq("rst_abort_busy", bus.busy, 1'b0);
        reset = 1'b0;
        saved = req_cycles;
        repeat (20) @(negedge clk);
        check_eq("rst_no_more_req", req_cycles, saved);
        pulse_flush();
        repeat (20) @(negedge clk);
        check_eq("rst_flush_noop", req_cycles, saved);
        check_eq("rst_flush_ready", bus.plot_ready, 1'b1);
        ack_delay = 0;

        // Flush pulse while a sequence is running.
        n_tx = 0;
        do_plot(16'd6, 3'd4, 4'h2);
        pulse_flush();
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.busy) done = 1'b1;
        end
        check_eq("fwb_busy_seen", done, 1'b1);
        pulse_flush();
        wait_seq("fwb");
        check_flush("fwb", 1'b1, 16'd6, 8'h00, 8'h08, 8'h00, 8'h00);
        saved = req_cycles;
        repeat (20) @(negedge clk);
        check_eq("fwb_no_second_seq", req_cycles, saved);
        do_plot(16'd6, 3'd5, 4'h7);
        repeat (20) @(negedge clk);
        check_eq("fwb_plot_no_seq", req_cycles, saved);
        n_tx = 0;
        pulse_flush();
        wait_seq("fwb2");
        check_flush("fwb2", 1'b1, 16'd6, 8'h04, 8'h04, 8'h04, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
